sntc_ldpc_iter_ctrl: RTL and testbench

Parametrised iteration controller for the LDPC decoder. It issues one-iteration requests to the decoder core and scores each iteration by the syndrome Hamming distance to exp_syn. Decoding terminates on convergence, on the loop limit, or on a stall (no improvement for a programmable number of iterations). It replaces the free-running HamDist counter and returns the best codeword found, the iteration count and the termination cause.

---
 rtl/sntc_ldpc_ctrl_pkg.sv | 26 ++
 rtl/sntc_syn_hamdist.sv | 22 ++
 rtl/sntc_ldpc_iter_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sntc_ldpc_iter_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sntc_ldpc_ctrl_pkg.sv
// Shared types and helpers for the LDPC iteration controller.
package sntc_ldpc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    EVAL  = 3'd3,
    FIN   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    CONV    = 2'd1,
    LOOPMAX = 2'd2,
    STALL   = 2'd3
  } term_cause_t;

  // Saturating +1 for a counter of width w (w <= 64), carried in a 64-bit container.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

endpackage

// File: rtl/sntc_syn_hamdist.sv
// Combinational syndrome Hamming distance: popcount(exp ^ cur).
module sntc_syn_hamdist #(
  parameter int MM   = 168,
  parameter int HD_W = $clog2(MM + 1)
) (
  input  logic [MM-1:0]   i_exp_syn,
  input  logic [MM-1:0]   i_cur_syn,
  output logic [HD_W-1:0] o_dist
);

  logic [MM-1:0] w_diff;

  assign w_diff = i_exp_syn ^ i_cur_syn;

  always_comb begin
    o_dist = '0;
    for (int i = 0; i < MM; i++) begin
      o_dist = o_dist + HD_W'(w_diff[i]);
    end
  end

endmodule

// File: rtl/sntc_ldpc_iter_ctrl.sv
// LDPC iteration controller: issues iterations, scores syndromes, stops on convergence/limit/stall.
// Optional SNTC_LDPC_BEST_CWORD_EN keeps the lowest-distance codeword instead of the last one.
module sntc_ldpc_iter_ctrl
  import sntc_ldpc_ctrl_pkg::*;
#(
  parameter int MM      = 168,
  parameter int NN      = 208,
  parameter int SUM_LEN = 32,
  parameter int HD_W    = $clog2(MM + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               start,
  input  logic [SUM_LEN-1:0] loop_max,
  input  logic [SUM_LEN-1:0] stall_max,
  input  logic [MM-1:0]      exp_syn,
  output logic               iter_req,
  input  logic               iter_done,
  input  logic [NN-1:0]      y_nr_in,
  input  logic [MM-1:0]      cur_syndrome,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [1:0]         term_cause,
  output logic [SUM_LEN-1:0] iter_cnt,
  output logic [HD_W-1:0]    hd_best,
  output logic [NN-1:0]      final_y_nr
);

  state_t             r_state, w_state_next;
  term_cause_t        r_cause, w_cause;
  logic [HD_W-1:0]    w_hd, r_hd, r_hd_best;
  logic [NN-1:0]      r_y_cap, r_final, w_best_next;
  logic [SUM_LEN-1:0] r_iter_cnt, r_stall_cnt;
  logic [SUM_LEN-1:0] w_iter_next, w_stall_next, w_loop_lim;
  logic               r_pass, w_improve;

  sntc_syn_hamdist #(
    .MM   (MM),
    .HD_W (HD_W)
  ) u_hamdist (
    .i_exp_syn (exp_syn),
    .i_cur_syn (cur_syndrome),
    .o_dist    (w_hd)
  );

  assign w_improve    = r_hd < r_hd_best;
  assign w_iter_next  = SUM_LEN'(sat_inc(64'(r_iter_cnt), SUM_LEN));
  assign w_stall_next = w_improve ? '0 : SUM_LEN'(sat_inc(64'(r_stall_cnt), SUM_LEN));
  assign w_loop_lim   = (loop_max == '0) ? SUM_LEN'(1) : loop_max;

  // First match wins: convergence, then loop limit, then stall.
  always_comb begin
    w_cause = NONE;
    if (r_hd == '0)
      w_cause = CONV;
    else if (w_iter_next >= w_loop_lim)
      w_cause = LOOPMAX;
    else if ((stall_max != '0) && (w_stall_next >= stall_max))
      w_cause = STALL;
  end

  always_comb begin
    w_state_next = r_state;
    iter_req     = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE:    if (start) w_state_next = ISSUE;
      ISSUE: begin
        iter_req     = 1'b1;
        w_state_next = WAIT;
      end
      WAIT:    if (iter_done) w_state_next = EVAL;
      EVAL:    w_state_next = (w_cause != NONE) ? FIN : ISSUE;
      FIN: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // A clear aborts silently, even in the cycle a pulse would have gone out.
    if (clr) begin
      w_state_next = IDLE;
      iter_req     = 1'b0;
      done         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

`ifdef SNTC_LDPC_BEST_CWORD_EN
  logic [NN-1:0] r_best_word;

  // Ties keep the earlier word, so only a strict improvement replaces it.
  assign w_best_next = w_improve ? r_y_cap : r_best_word;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_best_word <= '0;
    else if (clr)
      r_best_word <= '0;
    else if (r_state == EVAL)
      r_best_word <= w_best_next;
  end
`else
  assign w_best_next = r_y_cap;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hd        <= '0;
      r_y_cap     <= '0;
      r_iter_cnt  <= '0;
      r_stall_cnt <= '0;
      r_hd_best   <= '1;
      r_pass      <= 1'b0;
      r_cause     <= NONE;
      r_final     <= '0;
    end else if (clr) begin
      r_hd        <= '0;
      r_y_cap     <= '0;
      r_iter_cnt  <= '0;
      r_stall_cnt <= '0;
      r_hd_best   <= '1;
      r_pass      <= 1'b0;
      r_cause     <= NONE;
      r_final     <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_iter_cnt  <= '0;
          r_stall_cnt <= '0;
          r_hd_best   <= '1;
          r_pass      <= 1'b0;
          r_cause     <= NONE;
        end
        WAIT: if (iter_done) begin
          r_hd    <= w_hd;
          r_y_cap <= y_nr_in;
        end
        EVAL: begin
          r_iter_cnt  <= w_iter_next;
          r_stall_cnt <= w_stall_next;
          if (w_improve) r_hd_best <= r_hd;
          // Results are loaded on the terminating evaluation so they are valid alongside done.
          if (w_cause != NONE) begin
            r_cause <= w_cause;
            r_pass  <= (w_cause == CONV);
            r_final <= w_best_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state == ISSUE) || (r_state == WAIT) || (r_state == EVAL);
  assign pass       = r_pass;
  assign term_cause = r_cause;
  assign iter_cnt   = r_iter_cnt;
  assign hd_best    = r_hd_best;
  assign final_y_nr = r_final;

endmodule

// File: tb/tb_sntc_ldpc_iter_ctrl.sv
// Scoreboard bench for sntc_ldpc_iter_ctrl with a scripted decoder model.
module tb_sntc_ldpc_iter_ctrl;

  localparam int MM   = 168;
  localparam int NN   = 208;
  localparam int SL   = 32;
  localparam int HD_W = $clog2(MM + 1);

  typedef logic [255:0] v_t;

  typedef struct {
    logic [1:0]      cause;
    logic            pass;
    logic [SL-1:0]   iters;
    logic [HD_W-1:0] hd;
    logic [NN-1:0]   word;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            clr = 1'b0;
  logic            start = 1'b0;
  logic            iter_done = 1'b0;
  logic [SL-1:0]   loop_max = '0;
  logic [SL-1:0]   stall_max = '0;
  logic [MM-1:0]   exp_syn = '0;
  logic [MM-1:0]   cur_syndrome = '0;
  logic [NN-1:0]   y_nr_in = '0;
  logic            iter_req, busy, done, pass;
  logic [1:0]      term_cause;
  logic [SL-1:0]   iter_cnt;
  logic [HD_W-1:0] hd_best;
  logic [NN-1:0]   final_y_nr;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   req_cnt = 0;
  int   done_cnt = 0;

  sntc_ldpc_iter_ctrl #(.MM(MM), .NN(NN), .SUM_LEN(SL)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .clr          (clr),
    .start        (start),
    .loop_max     (loop_max),
    .stall_max    (stall_max),
    .exp_syn      (exp_syn),
    .iter_req     (iter_req),
    .iter_done    (iter_done),
    .y_nr_in      (y_nr_in),
    .cur_syndrome (cur_syndrome),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .term_cause   (term_cause),
    .iter_cnt     (iter_cnt),
    .hd_best      (hd_best),
    .final_y_nr   (final_y_nr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (iter_req) req_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input v_t got, input v_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NN-1:0] rand_word();
    logic [NN-1:0] v = '0;
    for (int i = 0; i < 7; i++) v = {v[NN-33:0], 32'($urandom())};
    return v;
  endfunction

  function automatic logic [MM-1:0] rand_syn();
    logic [MM-1:0] v = '0;
    for (int i = 0; i < 6; i++) v = {v[MM-33:0], 32'($urandom())};
    return v;
  endfunction

  // Syndrome exactly d bits away from exp_syn (11 is coprime to MM, so positions are distinct).
  function automatic logic [MM-1:0] syn_dist(input int d);
    logic [MM-1:0] m = '0;
    for (int i = 0; i < d; i++) m[(i * 11 + 3) % MM] = 1'b1;
    return exp_syn ^ m;
  endfunction

  task automatic run(input string name, input int lm, input int sm, input int n, input int dl[4],
                     input int e_cause, input int e_iters, input int e_hd, input int e_idx,
                     input bit noise, input int clr_iter);
    logic [NN-1:0] words[4];
    exp_t e;
    int   req0, done0, w, idx;
    for (int i = 0; i < 4; i++) words[i] = rand_word();
    exp_syn   = rand_syn();
    loop_max  = SL'(lm);
    stall_max = SL'(sm);
`ifdef SNTC_LDPC_BEST_CWORD_EN
    idx = e_idx;
`else
    idx = n - 1;
`endif
    if (clr_iter < 0) begin
      e.cause = 2'(e_cause);
      e.pass  = (e_cause == 1);
      e.iters = SL'(e_iters);
      e.hd    = HD_W'(e_hd);
      e.word  = words[idx];
      sb_q.push_back(e);
    end
    req0  = req_cnt;
    done0 = done_cnt;
    if (noise) begin
      cur_syndrome = exp_syn;
      iter_done = 1'b1;
      tick();
      iter_done = 1'b0;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_busy_on"}, v_t'(busy), v_t'(1));
    chk({name, "_cnt_cleared"}, v_t'(iter_cnt), v_t'(0));
    if (noise) iter_done = 1'b1;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (!iter_req && w < 16) begin
        tick();
        w++;
      end
      if (!iter_req) begin
        iter_done = 1'b0;
        chk({name, "_req_timeout"}, v_t'(0), v_t'(1));
        return;
      end
      chk({name, "_req_latency"}, v_t'(w), v_t'(0));
      tick();
      iter_done = 1'b0;
      if (noise) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (k == clr_iter) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk({name, "_clr_busy"}, v_t'(busy), v_t'(0));
        chk({name, "_clr_req"}, v_t'(iter_req), v_t'(0));
        chk({name, "_clr_pass"}, v_t'(pass), v_t'(0));
        chk({name, "_clr_cause"}, v_t'(term_cause), v_t'(0));
        chk({name, "_clr_iters"}, v_t'(iter_cnt), v_t'(0));
        chk({name, "_clr_hd"}, v_t'(hd_best), v_t'({HD_W{1'b1}}));
        chk({name, "_clr_final"}, v_t'(final_y_nr), v_t'(0));
        repeat (4) tick();
        chk({name, "_clr_no_done"}, v_t'(done_cnt - done0), v_t'(0));
        chk({name, "_clr_no_req"}, v_t'(req_cnt - req0), v_t'(k + 1));
        return;
      end
      tick();
      cur_syndrome = syn_dist(dl[k]);
      y_nr_in      = words[k];
      iter_done    = 1'b1;
      tick();
      iter_done = 1'b0;
      tick();
    end
    chk({name, "_done"}, v_t'(done), v_t'(1));
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, v_t'(0), v_t'(1));
      return;
    end
    e = sb_q.pop_front();
    chk({name, "_busy_fin"}, v_t'(busy), v_t'(0));
    chk({name, "_cause"}, v_t'(term_cause), v_t'(e.cause));
    chk({name, "_pass"}, v_t'(pass), v_t'(e.pass));
    chk({name, "_iters"}, v_t'(iter_cnt), v_t'(e.iters));
    chk({name, "_hd_best"}, v_t'(hd_best), v_t'(e.hd));
    chk({name, "_final"}, v_t'(final_y_nr), v_t'(e.word));
    chk({name, "_req_count"}, v_t'(req_cnt - req0), v_t'(n));
    tick();
    chk({name, "_done_pulse"}, v_t'(done), v_t'(0));
    chk({name, "_pass_held"}, v_t'(pass), v_t'(e.pass));
    chk({name, "_cause_held"}, v_t'(term_cause), v_t'(e.cause));
    $display("txn %s: cause=%0d pass=%0d iters=%0d hd_best=%0d", name, term_cause, pass, iter_cnt, hd_best);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_busy", v_t'(busy), v_t'(0));
    chk("rst_req", v_t'(iter_req), v_t'(0));
    chk("rst_done", v_t'(done), v_t'(0));
    chk("rst_pass", v_t'(pass), v_t'(0));
    chk("rst_cause", v_t'(term_cause), v_t'(0));
    chk("rst_iters", v_t'(iter_cnt), v_t'(0));
    chk("rst_hd", v_t'(hd_best), v_t'({HD_W{1'b1}}));
    chk("rst_final", v_t'(final_y_nr), v_t'(0));
    rstn = 1'b1;
    repeat (2) tick();

    run("conv",    10, 0, 3, '{5, 2, 0, 0}, 1, 3, 0, 2, 1'b0, -1);
    run("loopmax",  4, 0, 4, '{7, 6, 5, 4}, 2, 4, 4, 3, 1'b0, -1);
    run("stall",   20, 3, 4, '{3, 5, 3, 4}, 3, 4, 3, 0, 1'b0, -1);
    run("loop0",    0, 0, 1, '{9, 0, 0, 0}, 2, 1, 9, 0, 1'b0, -1);
    run("noise",    2, 0, 2, '{8, 8, 0, 0}, 2, 2, 8, 0, 1'b1, -1);
    run("clr",     10, 0, 4, '{6, 5, 0, 0}, 0, 0, 0, 0, 1'b0, 1);
    run("restart", 10, 0, 2, '{4, 0, 0, 0}, 1, 2, 0, 1, 1'b0, -1);

    chk("sb_drained", v_t'(sb_q.size()), v_t'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
